// File: rtl/mac_fx_stream_if.sv
// mac_fx_stream_if: operand-pair input stream and result output stream of the
// fixed-point MAC.
// Ports (signals): in_valid/in_ready/in_a/in_b/in_last carry (A,B) pairs in;
//   out_valid/out_ready/out_p/out_sat carry the per-vector result out.
// Modports: slave = the MAC itself, master = the source/sink facing it.
interface mac_fx_stream_if #(
  parameter int DW_I = 32,
  parameter int DW_O = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [DW_I-1:0] in_a;
  logic [DW_I-1:0] in_b;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW_O-1:0] out_p;
  logic            out_sat;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_p, out_sat
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_p, out_sat
  );
endinterface

// File: rtl/mac_fx_stream.sv
// mac_fx_stream: streaming signed fixed-point dot-product engine. Pairs enter
// through a MUL_LAT-deep multiplier pipeline, products are summed in a
// guard-extended accumulator, and each vector yields one rounded, saturated result.
// Ports: clk, rst_n (synchronous, active-low); bus (slave modport of
//   mac_fx_stream_if: input pair stream + result stream); busy (work in flight).
module mac_fx_stream #(
  parameter int DW_I    = 32,
  parameter int DW_O    = 32,
  parameter int FRAC    = 24,
  parameter int GUARD   = 8,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_fx_stream_if.slave        bus,
  output logic                  busy
);
  localparam int PW = 2 * DW_I;
  localparam int AW = PW + GUARD;

  // Rounding bias (half an output LSB) and the output range expressed at
  // accumulator width so the saturation compare is a plain signed compare.
  localparam logic signed [AW-1:0] RND   = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [AW-1:0] MAX_R = {{(AW-DW_O+1){1'b0}}, {(DW_O-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_R = {{(AW-DW_O+1){1'b1}}, {(DW_O-1){1'b0}}};

  typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;
  state_t state, state_nxt;

  logic                 accept;
  logic signed [PW-1:0] prod;
  logic [MUL_LAT-1:0]   pv;
  logic [MUL_LAT-1:0]   pl;
  logic signed [PW-1:0] pp [MUL_LAT];
  logic                 pv_o, pl_o;
  logic signed [AW-1:0] acc, acc_sum, acc_rnd, r;
  logic                 mid;      // at least one product of the current vector summed
  logic [DW_O-1:0]      out_p_q, res_p;
  logic                 out_sat_q, res_sat;

  assign accept = bus.in_valid && bus.in_ready;
  assign prod   = $signed(bus.in_a) * $signed(bus.in_b);
  assign pv_o   = pv[MUL_LAT-1];
  assign pl_o   = pl[MUL_LAT-1];

  // Multiplier pipeline: valids are reset, data/last-tag only move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv[0] <= accept;
      for (int i = 1; i < MUL_LAT; i++) pv[i] <= pv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pp[0] <= prod;
    pl[0] <= bus.in_last;
    for (int i = 1; i < MUL_LAT; i++) begin
      pp[i] <= pp[i-1];
      pl[i] <= pl[i-1];
    end
  end

  // The first product of a vector replaces the accumulator instead of adding.
  // The result is rounded/saturated from the sum being written, so it is
  // registered in the same edge that absorbs the last product.
  always_comb begin
    acc_sum = {{GUARD{pp[MUL_LAT-1][PW-1]}}, pp[MUL_LAT-1]};
    if (mid) acc_sum = acc + acc_sum;
    acc_rnd = acc_sum + RND;
    r       = acc_rnd >>> FRAC;
    res_p   = r[DW_O-1:0];
    res_sat = 1'b0;
    if (r > MAX_R) begin
      res_p   = MAX_R[DW_O-1:0];
      res_sat = 1'b1;
    end else if (r < MIN_R) begin
      res_p   = MIN_R[DW_O-1:0];
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      mid       <= 1'b0;
      out_p_q   <= '0;
      out_sat_q <= 1'b0;
    end else if (pv_o) begin
      acc <= acc_sum;
      mid <= !pl_o;
      if (pl_o) begin
        out_p_q   <= res_p;
        out_sat_q <= res_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && bus.in_last) state_nxt = DRAIN;
      DRAIN:   if (pv_o && pl_o)          state_nxt = HOLD;
      HOLD:    if (bus.out_ready)         state_nxt = ACC;
      default:                            state_nxt = ACC;
    endcase
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_p     = out_p_q;
  assign bus.out_sat   = out_sat_q;
  assign busy          = (state != ACC) || (|pv) || mid;
endmodule

// File: tb/tb_mac_fx_stream.sv
// tb_mac_fx_stream: directed bench for mac_fx_stream (DW_I=DW_O=32, FRAC=24,
// MUL_LAT=2). Inputs change and outputs are sampled on the falling edge.
module tb_mac_fx_stream;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   compared   = 0;
  int   mismatched = 0;
  int   pulses;

  always #5 clk = ~clk;

  mac_fx_stream_if #(.DW_I(32), .DW_O(32)) bus ();

  mac_fx_stream #(
    .DW_I(32), .DW_O(32), .FRAC(24), .GUARD(8), .MUL_LAT(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat; returns on the falling edge after it was sampled.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait (bounded) for a result, check it, then consume it.
  task automatic take(input string tag, input logic [31:0] ep, input logic es);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_p"},   64'(bus.out_p), 64'(ep));
    chk({tag, "_sat"}, 64'(bus.out_sat), 64'(es));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_rdy_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_p",     64'(bus.out_p), 64'd0);
    chk("rst_out_sat",   64'(bus.out_sat), 64'd0);
    chk("rst_busy",      64'(busy), 64'd0);

    // 1: 1.5 * 2.0 = 3.0, result visible MUL_LAT+1 cycles after acceptance
    drive(32'h0180_0000, 32'h0200_0000, 1'b1);
    chk("t1_lat0", 64'(bus.out_valid), 64'd0);
    chk("t1_rdy0", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk("t1_lat1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("t1_lat2", 64'(bus.out_valid), 64'd1);
    take("t1", 32'h0300_0000, 1'b0);

    // 2: four (1.0,1.0) pairs with a two-cycle bubble between beats 2 and 3
    drive(32'h0100_0000, 32'h0100_0000, 1'b0);
    drive(32'h0100_0000, 32'h0100_0000, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_busy_mid", 64'(busy), 64'd1);
    chk("t2_rdy_mid",  64'(bus.in_ready), 64'd1);
    chk("t2_vld_mid",  64'(bus.out_valid), 64'd0);
    drive(32'h0100_0000, 32'h0100_0000, 1'b0);
    drive(32'h0100_0000, 32'h0100_0000, 1'b1);
    take("t2", 32'h0400_0000, 1'b0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) pulses++;
    end
    chk("t2_single_pulse", 64'(pulses), 64'd0);
    chk("t2_idle_busy", 64'(busy), 64'd0);

    // 3: saturation on both ends
    drive(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    take("t3_pos", 32'h7FFF_FFFF, 1'b1);
    drive(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    take("t3_neg", 32'h8000_0000, 1'b1);

    // 4: round half-up at exactly half an LSB, positive and negative
    drive(32'h0000_0001, 32'h0080_0000, 1'b1);
    take("t4_pos", 32'h0000_0001, 1'b0);
    drive(32'hFFFF_FFFF, 32'h0080_0000, 1'b1);
    take("t4_neg", 32'h0000_0000, 1'b0);

    // 5: output backpressure while the source keeps offering a beat
    drive(32'h0100_0000, 32'h0300_0000, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_vld", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h0100_0000;
    bus.in_b     = 32'h0100_0000;
    bus.in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t5_hold_p",   64'(bus.out_p), 64'h0300_0000);
      chk("t5_hold_rdy", 64'(bus.in_ready), 64'd0);
      chk("t5_hold_vld", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t5_rel_vld", 64'(bus.out_valid), 64'd0);
    chk("t5_rel_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take("t5_next", 32'h0100_0000, 1'b0);

    // 6: reset in the middle of a vector, then a clean vector
    drive(32'h0100_0000, 32'h0100_0000, 1'b0);
    drive(32'h0100_0000, 32'h0100_0000, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_vld",  64'(bus.out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_rdy",  64'(bus.in_ready), 64'd1);
    drive(32'h0200_0000, 32'h0080_0000, 1'b1);
    take("t6", 32'h0100_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
